cordic_sincos: RTL and testbench
================================

# cordic_sincos

Iterative CORDIC in rotation mode. It takes an angle in the team's Q2.13 radian format (1.0 rad = 8192, π = 25736) and returns cos θ and sin θ as Q2.13 fixed-point values, where 1.0 = 8192. It is the inverse companion of the team's vectoring-mode arctan CORDIC: it feeds the phase-to-amplitude path using the same angle scaling and the same arctangent constant table.

## Interface
- WIDTH, 16: bit width of the angle input and of the cos/sin outputs. Must be ≥ 16; the table constants are sign-extended to WIDTH.
- STAGES, 13: number of CORDIC iterations. Legal range is 1..13, one table entry per iteration.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset. Assertion immediately forces the reset state; release is synchronous to clk.
- theta_in  input  WIDTH  signed angle, Q2.13 radians. Contract range is −25736..+25736.
- valid_in  input  1  request strobe. Sampled only while ready_out = 1.
- ready_out  output  1  high when in IDLE. Reset value 1.
- cos_out  output  WIDTH  signed cos θ, Q2.13. Reset value 0. Holds its last result.
- sin_out  output  WIDTH  signed sin θ, Q2.13. Reset value 0. Holds its last result.
- valid_out  output  1  one-cycle pulse marking new cos_out/sin_out. Reset value 0.

## Operation
- **States:**
  - IDLE → ROTATE on valid_in.
  - ROTATE → DONE after iteration STAGES−1.
  - DONE → IDLE unconditionally.
- **Accept (IDLE, valid_in = 1):**
  - Load x = K = 4975 (0x136F, 0.60725·8192), y = 0, iteration index i = 0.
  - Quadrant fold, result to z and negate flag:
    - If theta_in > 12868 (π/2): z = theta_in − 25736, neg = 1.
    - If theta_in < −12868: z = theta_in + 25736, neg = 1.
    - Otherwise z = theta_in, neg = 0.
- **ROTATE, one iteration per cycle, using table[i]:**
  - Table: 0x1921, 0x0ED6, 0x07D6, 0x03FA, 0x01FF, 0x00FF, 0x007F, 0x003F, 0x001F, 0x000F, 0x0007, 0x0003, 0x0001.
  - If z ≥ 0: x ← x − (y>>>i), y ← y + (x>>>i), z ← z − table[i].
  - If z < 0: x ← x + (y>>>i), y ← y − (x>>>i), z ← z + table[i].
  - Right-hand sides use the pre-edge x and y. Shifts are arithmetic. i increments.
  - No early exit: always exactly STAGES iterations.
- **On the edge leaving ROTATE:**
  - Register cos_out = neg ? −x : x and sin_out = neg ? −y : y, computed from the post-iteration values.
  - Enter DONE with valid_out = 1.
- **Width rules:**
  - x, y and z are held at WIDTH+2 bits internally, because intermediate gain reaches ≈1.0·8192·√2.
  - Final results lie within ±8200 and are truncated to WIDTH without saturation.
- **Input restrictions:**
  - valid_in in ROTATE or DONE is ignored. There is no queueing, and inputs are not re-sampled.
  - theta_in outside the contract range produces unspecified values, but handshake timing is unchanged.
- **Reset mid-operation:** on rst_n assertion, state goes to IDLE, and x, y, z, i, neg, cos_out, sin_out and valid_out go to 0. ready_out = 1 while in reset and afterward.

## Timing
- Accept edge A: theta_in and valid_in are sampled, and ready_out falls after A.
- ROTATE occupies edges A+1..A+STAGES.
- valid_out is high for exactly the one cycle after edge A+STAGES, and cos_out/sin_out change on that same edge.
- DONE → IDLE occurs at edge A+STAGES+1, and ready_out rises after it.
- The earliest next accept is edge A+STAGES+2. Sustained throughput is one result per STAGES+2 cycles.
- Between valid_out pulses, outputs are stable.

## Test plan
- theta_in = 0 → after exactly 13 edges, valid_out pulses once, with cos_out = 8192 ±16 and sin_out = 0 ±16. ready_out is low throughout the 14 busy cycles.
- theta_in = 12868 (π/2) → cos_out = 0 ±16, sin_out = 8192 ±16.
- Quadrant fold cases:
  - theta_in = −6434 (−π/4) → cos_out = 5793 ±16, sin_out = −5793 ±16.
  - theta_in = 25736 (π) → cos_out = −8192 ±16, sin_out = 0 ±16.
  - theta_in = −19302 (−3π/4) → cos_out = −5793 ±16, sin_out = −5793 ±16.
- Busy handling:
  - Accept 0x0000, then hold valid_in = 1 with theta_in = 12868 through ROTATE/DONE → the first result corresponds to θ = 0.
  - The second accept happens only at edge A+15, and its result appears 13 edges later.
- Reset mid-rotation: assert rst_n = 0 asynchronously at ROTATE iteration 5 → cos_out = 0, sin_out = 0 and valid_out = 0 immediately, ready_out = 1, and no valid_out pulse after release. A new request then completes normally.
- Sweep theta_in across −25736..25736 in steps of 257 → every |error| versus a real-valued cos/sin·8192 is ≤ 16 LSB, and every request yields exactly one valid_out pulse.

Source files
------------

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: Q2.13 angle in, Q2.13 cos/sin out.
// One micro-rotation per clock, quadrant folded on accept so z stays within +/-pi/2.
module cordic_sincos #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] theta_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic signed [WIDTH-1:0] cos_out,
    output logic signed [WIDTH-1:0] sin_out,
    output logic                    valid_out
);

    localparam int IW    = WIDTH + 2;
    localparam int IDX_W = 4;
    localparam int TBL_N = 1 << IDX_W;

    localparam logic signed [IW-1:0] K_INIT  = IW'(4975);
    localparam logic signed [IW-1:0] HALF_PI = IW'(12868);
    localparam logic signed [IW-1:0] PI      = IW'(25736);
    localparam logic [IDX_W-1:0]     LAST_IT = IDX_W'(STAGES - 1);

    // Element 0 is atan(2^0)*8192; listed MSB-first so index 0 is the last entry.
    localparam logic [12:0][15:0] ATAN_TABLE = {
        16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001F, 16'h003F, 16'h007F,
        16'h00FF, 16'h01FF, 16'h03FA, 16'h07D6, 16'h0ED6, 16'h1921
    };

    typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

    state_t                 state_reg;
    logic signed [IW-1:0]   x_reg, y_reg, z_reg;
    logic [IDX_W-1:0]       iter_reg;
    logic                   neg_reg;

    logic signed [IW-1:0]   atan_ext [TBL_N];
    logic signed [IW-1:0]   atan_cur;
    logic signed [IW-1:0]   x_shift, y_shift;
    logic signed [IW-1:0]   x_next, y_next, z_next;
    logic signed [IW-1:0]   theta_ext;

    generate
        for (genvar gi = 0; gi < TBL_N; gi++) begin : g_atan
            if (gi < 13) begin : g_entry
                assign atan_ext[gi] = {{(IW-16){ATAN_TABLE[gi][15]}}, ATAN_TABLE[gi]};
            end else begin : g_pad
                assign atan_ext[gi] = '0;
            end
        end
    endgenerate

    assign atan_cur  = atan_ext[iter_reg];
    assign x_shift   = x_reg >>> iter_reg;
    assign y_shift   = y_reg >>> iter_reg;
    assign theta_ext = {{2{theta_in[WIDTH-1]}}, theta_in};

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        z_next = z_reg;
        if (!z_reg[IW-1]) begin
            x_next = x_reg - y_shift;
            y_next = y_reg + x_shift;
            z_next = z_reg - atan_cur;
        end else begin
            x_next = x_reg + y_shift;
            y_next = y_reg - x_shift;
            z_next = z_reg + atan_cur;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            iter_reg  <= '0;
            neg_reg   <= 1'b0;
            cos_out   <= '0;
            sin_out   <= '0;
            valid_out <= 1'b0;
            ready_out <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    valid_out <= 1'b0;
                    if (valid_in) begin
                        x_reg     <= K_INIT;
                        y_reg     <= '0;
                        iter_reg  <= '0;
                        ready_out <= 1'b0;
                        state_reg <= ROTATE;
                        // Angles beyond +/-pi/2 rotate by pi and negate the result.
                        if (theta_ext > HALF_PI) begin
                            z_reg   <= theta_ext - PI;
                            neg_reg <= 1'b1;
                        end else if (theta_ext < -HALF_PI) begin
                            z_reg   <= theta_ext + PI;
                            neg_reg <= 1'b1;
                        end else begin
                            z_reg   <= theta_ext;
                            neg_reg <= 1'b0;
                        end
                    end
                end
                ROTATE: begin
                    x_reg    <= x_next;
                    y_reg    <= y_next;
                    z_reg    <= z_next;
                    iter_reg <= iter_reg + 1'b1;
                    if (iter_reg == LAST_IT) begin
                        cos_out   <= WIDTH'(neg_reg ? -x_next : x_next);
                        sin_out   <= WIDTH'(neg_reg ? -y_next : y_next);
                        valid_out <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    valid_out <= 1'b0;
                    ready_out <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    valid_out <= 1'b0;
                    ready_out <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sincos.sv
// Directed bench for cordic_sincos: timing, quadrant folds, busy handling,
// asynchronous reset mid-rotation and an angle sweep against real cos/sin.
module tb_cordic_sincos;

    localparam int WIDTH  = 16;
    localparam int STAGES = 13;
    localparam real TOL   = 16.0;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic signed [WIDTH-1:0] theta_in;
    logic                    valid_in;
    logic                    ready_out;
    logic signed [WIDTH-1:0] cos_out;
    logic signed [WIDTH-1:0] sin_out;
    logic                    valid_out;

    int tests = 0;
    int fails = 0;

    cordic_sincos #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .theta_in  (theta_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .cos_out   (cos_out),
        .sin_out   (sin_out),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_near(input string tag, input int observed, input real expected);
        real diff;
        tests++;
        diff = real'(observed) - expected;
        if (diff < 0.0) diff = -diff;
        assert ((diff <= TOL) === 1'b1) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0.1f +/-16", tag, observed, expected);
        end
    endtask

    // One request: accept on edge A, result after edge A+STAGES, idle after A+STAGES+1.
    // With hold set, valid_in stays high and theta_in switches to hold_theta after accept.
    task automatic run_req(input int theta, input real exp_c, input real exp_s,
                           input string tag, input bit hold, input int hold_theta);
        int wait_n;
        int pulses;
        int ready_hi;
        wait_n = 0;
        while (ready_out !== 1'b1 && wait_n < 40) begin
            @(negedge clk);
            wait_n++;
        end
        check_eq({tag, "_ready_before"}, int'(ready_out), 1);
        theta_in = WIDTH'(theta);
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (hold) theta_in = WIDTH'(hold_theta);
        else valid_in = 1'b0;
        check_eq({tag, "_ready_after_accept"}, int'(ready_out), 0);
        pulses   = 0;
        ready_hi = 0;
        for (int k = 1; k <= STAGES; k++) begin
            @(negedge clk);
            if (valid_out === 1'b1) pulses++;
            if (ready_out !== 1'b0) ready_hi++;
            if (k == STAGES) begin
                check_eq({tag, "_valid_at_latency"}, int'(valid_out), 1);
                check_near({tag, "_cos"}, int'(cos_out), exp_c);
                check_near({tag, "_sin"}, int'(sin_out), exp_s);
            end
        end
        check_eq({tag, "_ready_low_busy"}, ready_hi, 0);
        @(negedge clk);
        if (valid_out === 1'b1) pulses++;
        check_eq({tag, "_ready_back"}, int'(ready_out), 1);
        check_eq({tag, "_pulse_count"}, pulses, 1);
    endtask

    initial begin
        int pulses;
        rst_n    = 1'b0;
        theta_in = '0;
        valid_in = 1'b0;

        #12;
        check_eq("reset_ready", int'(ready_out), 1);
        check_eq("reset_valid", int'(valid_out), 0);
        check_eq("reset_cos", int'(cos_out), 0);
        check_eq("reset_sin", int'(sin_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_req(0,      8192.0,  0.0,    "zero",        1'b0, 0);
        run_req(12868,  0.0,     8192.0, "half_pi",     1'b0, 0);
        run_req(-12868, 0.0,    -8192.0, "neg_half_pi", 1'b0, 0);
        run_req(4289,   7094.5,  4096.0, "pi_6",        1'b0, 0);
        run_req(-6434,  5793.0, -5793.0, "neg_pi_4",    1'b0, 0);
        run_req(25736, -8192.0,  0.0,    "pi",          1'b0, 0);
        run_req(12869, -1.0,     8192.0, "above_half",  1'b0, 0);
        run_req(-19302, -5793.0, -5793.0, "neg_3pi_4",  1'b0, 0);

        // Reset asserted while ROTATE is on iteration 5.
        while (ready_out !== 1'b1) @(negedge clk);
        theta_in = WIDTH'(4289);
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_cos", int'(cos_out), 0);
        check_eq("rst_mid_sin", int'(sin_out), 0);
        check_eq("rst_mid_valid", int'(valid_out), 0);
        check_eq("rst_mid_ready", int'(ready_out), 1);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (valid_out === 1'b1) pulses++;
        end
        check_eq("rst_no_pulse", pulses, 0);
        check_eq("rst_ready_idle", int'(ready_out), 1);
        run_req(6434, 5793.0, 5793.0, "post_reset", 1'b0, 0);

        // Busy: valid_in held high with a new angle; first result must still be theta=0,
        // and the second accept lands on edge A+STAGES+2.
        run_req(0,     8192.0, 0.0,    "busy_first",  1'b1, 12868);
        run_req(12868, 0.0,    8192.0, "busy_second", 1'b0, 0);

        for (int t = -25736; t <= 25736; t += 257) begin
            run_req(t, $cos(real'(t) / 8192.0) * 8192.0, $sin(real'(t) / 8192.0) * 8192.0,
                    $sformatf("sweep_%0d", t), 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
